silife_frame_seq: RTL and testbench
===================================

SILIFE_FRAME_SEQ -- requirements
Module: silife_frame_seq

Interface
REQ-001 SHALL have parameter HEIGHT, default 8, the number of display rows per frame (2..256).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: run request for the scan sequence.
REQ-005 SHALL have port cycles, input, 16 bits: row dwell; each row is driven for cycles+1 clocks.
REQ-006 SHALL have port blank, input, 4 bits: blanking clocks inserted after each row (0 = none).
REQ-007 SHALL have port upd_req, input, 1 bit: the life engine requests exclusive access to the cell grid.
REQ-008 SHALL have port upd_ack, output, 1 bit: grant; high only in state UPDATE.
REQ-009 SHALL have port row, output, 8 bits: current row index driven to the scan datapath.
REQ-010 SHALL have port row_valid, output, 1 bit: row/column drivers may be active; high only in state SCAN.
REQ-011 SHALL have port frame_start, output, 1 bit: one-clock pulse on the first SCAN clock of row 0.
REQ-012 SHALL have port frame_count, output, 8 bits: count of completed frames, wrapping 255->0.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, BLANK and UPDATE, with a 16-bit dwell counter and a 4-bit blank counter.
REQ-014 IDLE: row=0, row_valid=0; when enable=1 and cycles!=0, go to SCAN with row=0 and pulse frame_start.
REQ-015 SCAN: row_valid=1; if counter<cycles, counter increments; if counter>=cycles, counter clears and the row ends.
REQ-016 Row end with blank!=0: go to BLANK and load the blank counter; row stays unchanged.
REQ-017 BLANK: row_valid=0; after exactly blank clocks in BLANK, perform row advance.
REQ-018 Row end with blank=0: perform row advance directly, with no idle clock between rows.
REQ-019 Row advance, row<HEIGHT-1: row increments and FSM enters SCAN.
REQ-020 Row advance, row=HEIGHT-1 (frame end): frame_count increments; if upd_req=1 go to UPDATE, else row=0, SCAN, pulse frame_start.
REQ-021 UPDATE: upd_ack=1, row_valid=0, row=0; when upd_req=0, go to SCAN with a frame_start pulse if enable=1, else go to IDLE.
REQ-022 upd_req SHALL be sampled only at frame end; a request raised mid-frame waits; the grant never interrupts a frame.
REQ-023 enable=0 in SCAN or BLANK: next state IDLE; the partial frame does not count.
REQ-024 enable=0 in UPDATE: ignored until upd_req falls.
REQ-025 cycles=0 in SCAN: counter and row hold, row_valid stays 1 (static row); upd_req is not granted in this condition.
REQ-026 cycles or blank changing mid-row SHALL take effect on the next comparison clock.
REQ-027 upd_ack and row_valid SHALL never be high in the same cycle.
REQ-028 All outputs SHALL be registered.
REQ-029 Frame period with no update SHALL be HEIGHT*(cycles+1+blank) clocks.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, row=0, both counters=0, frame_count=0, row_valid=0, upd_ack=0 and frame_start=0.
REQ-031 Reset asserted during UPDATE SHALL drop upd_ack at once; the engine must re-request.
REQ-032 After reset_n rises, the first SCAN SHALL start on the first clock edge that sees enable=1 and cycles!=0.

Verification
REQ-033 HEIGHT=8, cycles=3, blank=0, enable=1: rows 0..7 each held 4 clocks; frame_start every 32 clocks; frame_count 1 after the first frame.
REQ-034 cycles=1, blank=2: per row, row_valid high 2 clocks then low 2 clocks; frame period 32 clocks.
REQ-035 upd_req raised during row 3 and held: upd_ack rises only after row 7 completes; held 5 clocks, then upd_req=0 -> next clock SCAN row 0 with frame_start.
REQ-036 enable dropped during row 5: IDLE next clock, row=0, frame_count unchanged; re-enable -> frame_start and row 0.
REQ-037 reset_n pulsed low mid-UPDATE and mid-BLANK: all outputs 0 asynchronously; normal start resumes per REQ-032.
REQ-038 cycles=0 after enable: row 0 static, row_valid=1 indefinitely; upd_ack stays 0 despite upd_req=1.

Source files
------------

// File: rtl/silife_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : silife_frame_seq
// Brief    : Row-scan frame sequencer for the life display, with per-row dwell,
//            optional blanking and frame-boundary grid-update handshake.
// Revision : 1.0  initial release
// ============================================================================
module silife_frame_seq #(
    parameter int HEIGHT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] cycles,
    input  logic [3:0]  blank,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [7:0]  row,
    output logic        row_valid,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam logic [7:0] C_LAST_ROW = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_BLANK  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_dwell;
    logic [3:0]  r_blank;
    logic [7:0]  r_row;
    logic        r_row_valid;
    logic        r_frame_start;
    logic        r_upd_ack;
    logic [7:0]  r_frame_count;

    logic w_run;
    logic w_scan_end;
    logic w_adv;

    // cycles==0 freezes the current row, so it never produces a row end
    assign w_run      = enable && (cycles != 16'd0);
    assign w_scan_end = (r_state == ST_SCAN) && w_run && (r_dwell >= cycles);
    assign w_adv      = (w_scan_end && (blank == 4'd0)) ||
                        ((r_state == ST_BLANK) && enable && (r_blank <= 4'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_dwell       <= 16'd0;
            r_blank       <= 4'd0;
            r_row         <= 8'd0;
            r_row_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_upd_ack     <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_run) begin
                        r_state       <= ST_SCAN;
                        r_row         <= 8'd0;
                        r_dwell       <= 16'd0;
                        r_row_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!enable) begin
                        r_state     <= ST_IDLE;
                        r_row       <= 8'd0;
                        r_dwell     <= 16'd0;
                        r_blank     <= 4'd0;
                        r_row_valid <= 1'b0;
                    end else if (cycles != 16'd0) begin
                        if (r_dwell < cycles) begin
                            r_dwell <= r_dwell + 16'd1;
                        end else begin
                            r_dwell <= 16'd0;
                            if (blank != 4'd0) begin
                                r_state     <= ST_BLANK;
                                r_blank     <= blank;
                                r_row_valid <= 1'b0;
                            end
                        end
                    end
                end
                ST_BLANK: begin
                    if (!enable) begin
                        r_state     <= ST_IDLE;
                        r_row       <= 8'd0;
                        r_dwell     <= 16'd0;
                        r_blank     <= 4'd0;
                        r_row_valid <= 1'b0;
                    end else if (r_blank > 4'd1) begin
                        r_blank <= r_blank - 4'd1;
                    end
                end
                ST_UPDATE: begin
                    if (!upd_req) begin
                        r_upd_ack <= 1'b0;
                        r_dwell   <= 16'd0;
                        if (enable) begin
                            r_state       <= ST_SCAN;
                            r_row_valid   <= 1'b1;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Row advance overrides the per-state updates above
            if (w_adv) begin
                r_dwell <= 16'd0;
                r_blank <= 4'd0;
                if (r_row < C_LAST_ROW) begin
                    r_row       <= r_row + 8'd1;
                    r_state     <= ST_SCAN;
                    r_row_valid <= 1'b1;
                end else begin
                    r_frame_count <= r_frame_count + 8'd1;
                    r_row         <= 8'd0;
                    if (upd_req) begin
                        r_state     <= ST_UPDATE;
                        r_upd_ack   <= 1'b1;
                        r_row_valid <= 1'b0;
                    end else begin
                        r_state       <= ST_SCAN;
                        r_row_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                    end
                end
            end
        end
    end

    assign upd_ack     = r_upd_ack;
    assign row         = r_row;
    assign row_valid   = r_row_valid;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_silife_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_silife_frame_seq
// Brief    : Scoreboard bench for silife_frame_seq (HEIGHT=8) using directed
//            scan, blank, update, enable-drop and reset scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_silife_frame_seq;

    localparam int C_HEIGHT = 8;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] cycles;
    logic [3:0]  blank;
    logic        upd_req;
    logic        upd_ack;
    logic [7:0]  row;
    logic        row_valid;
    logic        frame_start;
    logic [7:0]  frame_count;

    silife_frame_seq #(.HEIGHT(C_HEIGHT)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cycles      (cycles),
        .blank       (blank),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .row         (row),
        .row_valid   (row_valid),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    typedef struct {
        int         stamp;
        string      tag;
        logic [7:0] row;
        logic       rv;
        logic       fs;
        logic       ack;
        logic [7:0] fc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation stamped with the current cycle is checked
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (row !== e.row || row_valid !== e.rv || frame_start !== e.fs ||
                upd_ack !== e.ack || frame_count !== e.fc) begin
                n_err++;
                $display("FAIL %s cyc=%0d: got row=%0d rv=%b fs=%b ack=%b fc=%0d, want row=%0d rv=%b fs=%b ack=%b fc=%0d",
                         e.tag, e.stamp, row, row_valid, frame_start, upd_ack, frame_count,
                         e.row, e.rv, e.fs, e.ack, e.fc);
            end
        end
    end

    task automatic push(input int stamp, input string tag, input int r, input bit rv,
                        input bit fs, input bit ack, input int fc);
        exp_t e;
        e.stamp = stamp; e.tag = tag; e.row = 8'(r); e.rv = rv;
        e.fs = fs; e.ack = ack; e.fc = 8'(fc);
        q.push_back(e);
    endtask

    // Expected outputs of a free-running scan started at edge base+1
    task automatic push_run(input int base, input string tag, input int k0, input int k1,
                            input int per_row, input int scan_len, input int fc0);
        for (int k = k0; k <= k1; k++) begin
            int idx;
            idx = k - 1;
            push(base + k, tag, (idx / per_row) % C_HEIGHT, (idx % per_row) < scan_len,
                 (idx % (C_HEIGHT * per_row)) == 0, 1'b0, fc0 + idx / (C_HEIGHT * per_row));
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
            q.delete();
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (row !== 8'd0 || row_valid !== 1'b0 || frame_start !== 1'b0 ||
            upd_ack !== 1'b0 || frame_count !== 8'd0) begin
            n_err++;
            $display("FAIL %s: got row=%0d rv=%b fs=%b ack=%b fc=%0d, want all 0",
                     tag, row, row_valid, frame_start, upd_ack, frame_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        cycles  = 16'd3;
        blank   = 4'd0;
        upd_req = 1'b0;

        // Reset state, and IDLE holding while enable=0 or cycles=0
        do_reset("reset_init");
        m = cyc;
        push(m + 1, "idle_off", 0, 0, 0, 0, 0);
        push(m + 2, "idle_off", 0, 0, 0, 0, 0);
        wait_cyc(m + 2);
        enable = 1'b1; cycles = 16'd0;
        push(m + 3, "idle_cyc0", 0, 0, 0, 0, 0);
        push(m + 4, "idle_cyc0", 0, 0, 0, 0, 0);
        wait_cyc(m + 4);

        // cycles=3, blank=0: 4 clocks per row, 32-clock frames
        cycles = 16'd3;
        m = cyc;
        push_run(m, "scan_c3", 1, 40, 4, 4, 0);
        wait_cyc(m + 40);
        enable = 1'b0;
        push(m + 41, "scan_stop", 0, 0, 0, 0, 1);
        drain();

        // cycles=1, blank=2: 2 on / 2 blank per row, then reset mid-BLANK
        do_reset("reset_pre_blank");
        cycles = 16'd1; blank = 4'd2; enable = 1'b1;
        m = cyc;
        push_run(m, "blank_c1b2", 1, 34, 4, 2, 0);
        wait_cyc(m + 34);
        do_reset("reset_mid_blank");
        enable = 1'b0;
        drain();

        // Update request raised mid-frame, granted only at frame end
        do_reset("reset_pre_upd");
        cycles = 16'd3; blank = 4'd0; enable = 1'b1;
        m = cyc;
        push_run(m, "upd_frame", 1, 32, 4, 4, 0);
        for (int k = 33; k <= 37; k++) push(m + k, "upd_grant", 0, 0, 0, 1, 1);
        wait_cyc(m + 14);
        upd_req = 1'b1;
        wait_cyc(m + 37);
        upd_req = 1'b0;
        push(m + 38, "upd_resume", 0, 1, 1, 0, 1);
        for (int k = 39; k <= 41; k++) push(m + k, "upd_resume", 0, 1, 0, 0, 1);
        wait_cyc(m + 41);
        drain();

        // Enable dropped during row 5, then re-enabled
        do_reset("reset_pre_drop");
        m = cyc;
        push_run(m, "drop_run", 1, 22, 4, 4, 0);
        wait_cyc(m + 22);
        enable = 1'b0;
        push(m + 23, "drop_idle", 0, 0, 0, 0, 0);
        push(m + 24, "drop_idle", 0, 0, 0, 0, 0);
        wait_cyc(m + 24);
        enable = 1'b1;
        push_run(m + 24, "drop_reen", 1, 4, 4, 4, 0);
        wait_cyc(m + 28);
        drain();

        // Reset mid-UPDATE, restart without re-request granting upd_ack
        do_reset("reset_pre_updrst");
        cycles = 16'd1; upd_req = 1'b1;
        m = cyc;
        push_run(m, "updrst_frame", 1, 16, 2, 2, 0);
        push(m + 17, "updrst_grant", 0, 0, 0, 1, 1);
        push(m + 18, "updrst_grant", 0, 0, 0, 1, 1);
        wait_cyc(m + 18);
        do_reset("reset_mid_update");
        m = cyc;
        push_run(m, "updrst_restart", 1, 3, 2, 2, 0);
        wait_cyc(m + 3);
        drain();

        // cycles=0 after start: static row 0, no grant
        do_reset("reset_pre_static");
        cycles = 16'd2;
        m = cyc;
        push(m + 1, "static_row", 0, 1, 1, 0, 0);
        wait_cyc(m + 1);
        cycles = 16'd0;
        for (int k = 2; k <= 12; k++) push(m + k, "static_row", 0, 1, 0, 0, 0);
        wait_cyc(m + 12);
        drain();

        // enable=0 during UPDATE is ignored until upd_req falls, then IDLE
        do_reset("reset_pre_updoff");
        cycles = 16'd1; upd_req = 1'b1;
        m = cyc;
        push_run(m, "updoff_frame", 1, 16, 2, 2, 0);
        push(m + 17, "updoff_grant", 0, 0, 0, 1, 1);
        wait_cyc(m + 17);
        enable = 1'b0;
        push(m + 18, "updoff_hold", 0, 0, 0, 1, 1);
        push(m + 19, "updoff_hold", 0, 0, 0, 1, 1);
        wait_cyc(m + 19);
        upd_req = 1'b0;
        push(m + 20, "updoff_idle", 0, 0, 0, 0, 1);
        push(m + 21, "updoff_idle", 0, 0, 0, 0, 1);
        wait_cyc(m + 21);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
